// File: rtl/fetch_ctrl.sv
// Purpose : fetch sequencer; drives PC register controls, imem read enable and fetch-valid tagging.
// Latency : sel_pc/dp_pc/imem_en/flush combinational; ir_valid, halted, bkpt_hit, fetch_cnt registered (1 cycle).
// Backpress: stall holds the PC with no fetch issued and keeps ir_valid; branch/start/halt override stall.
//
// Ports: clk, rst_n (async active-low); start/start_pc (entry), pc_out (PC feedback),
//        branch_taken/branch_target, stall, halt, bkpt_valid/bkpt_addr (inputs);
//        sel_pc (01 load start_pc, 11 load dp_pc, 00 increment), dp_pc, imem_en, ir_valid,
//        flush, halted, bkpt_hit, fetch_cnt (outputs).
// Option : define FETCH_CTRL_BKPT_EN to enable the address breakpoint; otherwise the
//          breakpoint inputs are ignored and bkpt_hit stays 0.
module fetch_ctrl #(
    parameter int PC_W  = 11,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PC_W-1:0]  start_pc,
    input  logic [PC_W-1:0]  pc_out,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             stall,
    input  logic             halt,
    input  logic             bkpt_valid,
    input  logic [PC_W-1:0]  bkpt_addr,
    output logic [1:0]       sel_pc,
    output logic [PC_W-1:0]  dp_pc,
    output logic             imem_en,
    output logic             ir_valid,
    output logic             flush,
    output logic             halted,
    output logic             bkpt_hit,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [1:0] SEL_INC   = 2'b00;
    localparam logic [1:0] SEL_START = 2'b01;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    state_t state;
    state_t state_nxt;
    logic   ir_valid_nxt;
    logic   bkpt_set;
    logic   start_acc;
    logic   bkpt_match;

`ifdef FETCH_CTRL_BKPT_EN
    assign bkpt_match = bkpt_valid && (pc_out == bkpt_addr);
`else
    logic unused_bkpt;
    assign unused_bkpt = ^{bkpt_valid, bkpt_addr};
    assign bkpt_match  = 1'b0;
`endif

    // The PC register has no hold code: holding is "load dp_pc" with dp_pc = pc_out,
    // which is the default below for every non-fetching cycle.
    always_comb begin
        sel_pc       = SEL_LOAD;
        dp_pc        = pc_out;
        imem_en      = 1'b0;
        flush        = 1'b0;
        state_nxt    = state;
        ir_valid_nxt = 1'b0;
        bkpt_set     = 1'b0;
        start_acc    = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    sel_pc    = SEL_START;
                    state_nxt = S_RUN;
                    start_acc = 1'b1;
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_nxt = S_HALT;
                end else if (start) begin
                    sel_pc    = SEL_START;
                    flush     = 1'b1;
                    start_acc = 1'b1;
                end else if (branch_taken) begin
                    dp_pc = branch_target;
                    flush = 1'b1;
                end else if (bkpt_match) begin
                    // Block the fetch at the breakpoint address itself.
                    state_nxt = S_HALT;
                    bkpt_set  = 1'b1;
                end else if (stall) begin
                    ir_valid_nxt = ir_valid;
                end else begin
                    sel_pc       = SEL_INC;
                    imem_en      = 1'b1;
                    ir_valid_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ir_valid  <= 1'b0;
            halted    <= 1'b0;
            bkpt_hit  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ir_valid  <= ir_valid_nxt;
            halted    <= (state_nxt == S_HALT);
            if (start_acc) begin
                bkpt_hit <= 1'b0;
            end else if (bkpt_set) begin
                bkpt_hit <= 1'b1;
            end
            // Free-running; wraps naturally at CNT_W bits.
            fetch_cnt <= fetch_cnt + CNT_W'(imem_en);
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int PC_W  = 11;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [PC_W-1:0]  start_pc = '0;
    logic [PC_W-1:0]  pc_out;
    logic             branch_taken = 1'b0;
    logic [PC_W-1:0]  branch_target = '0;
    logic             stall = 1'b0;
    logic             halt = 1'b0;
    logic             bkpt_valid = 1'b0;
    logic [PC_W-1:0]  bkpt_addr = '0;
    logic [1:0]       sel_pc;
    logic [PC_W-1:0]  dp_pc;
    logic             imem_en;
    logic             ir_valid;
    logic             flush;
    logic             halted;
    logic             bkpt_hit;
    logic [CNT_W-1:0] fetch_cnt;

    fetch_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .pc_out(pc_out),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .halt(halt), .bkpt_valid(bkpt_valid), .bkpt_addr(bkpt_addr), .sel_pc(sel_pc),
        .dp_pc(dp_pc), .imem_en(imem_en), .ir_valid(ir_valid), .flush(flush),
        .halted(halted), .bkpt_hit(bkpt_hit), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Environment PC register, steered only by the DUT's controls.
    logic [PC_W-1:0] pc_reg = '0;
    assign pc_out = pc_reg;
    always @(posedge clk) begin
        case (sel_pc)
            2'b01:   pc_reg <= start_pc;
            2'b11:   pc_reg <= dp_pc;
            2'b00:   pc_reg <= pc_reg + 1'b1;
            default: pc_reg <= pc_reg;
        endcase
    end

    typedef struct {
        logic [1:0]       sel;
        logic [PC_W-1:0]  dp;
        logic             en;
        logic             fl;
        logic             irv;
        logic             hlt;
        logic             bk;
        logic [CNT_W-1:0] cnt;
        logic [PC_W-1:0]  faddr;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: what the machine is doing (idle/running/halted), where the
    // PC should be, whether the last cycle delivered an instruction, how many fetches.
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
    int              m_mode = M_IDLE;
    logic [PC_W-1:0] m_pc   = '0;
    bit              m_irv  = 0;
    bit              m_bkpt = 0;
    int unsigned     m_cnt  = 0;

    task automatic cyc(input bit st, input logic [PC_W-1:0] spc, input bit bt,
                       input logic [PC_W-1:0] btg, input bit stl, input bit hlt,
                       input bit bv, input logic [PC_W-1:0] ba);
        exp_t e;
        string ev;
        bit bk_on;
        @(posedge clk);
        #1;
        start = st; start_pc = spc; branch_taken = bt; branch_target = btg;
        stall = stl; halt = hlt; bkpt_valid = bv; bkpt_addr = ba;
`ifdef FETCH_CTRL_BKPT_EN
        bk_on = 1;
`else
        bk_on = 0;
`endif
        // Registered outputs show the history up to this cycle.
        e.irv = m_irv; e.hlt = (m_mode == M_HALT); e.bk = m_bkpt;
        e.cnt = CNT_W'(m_cnt); e.faddr = m_pc;
        // Decide which single event this cycle represents.
        if (m_mode != M_RUN)            ev = st ? "start" : "hold";
        else if (hlt)                   ev = "halt";
        else if (st)                    ev = "restart";
        else if (bt)                    ev = "branch";
        else if (bk_on && bv && m_pc == ba) ev = "bkpt";
        else if (stl)                   ev = "stall";
        else                            ev = "fetch";
        e.sel = 2'b11; e.dp = m_pc; e.en = 0; e.fl = 0;
        if (ev == "start" || ev == "restart") begin
            e.sel = 2'b01; e.fl = (ev == "restart");
            m_pc = spc; m_mode = M_RUN; m_bkpt = 0; m_irv = 0;
        end else if (ev == "halt") begin
            m_mode = M_HALT; m_irv = 0;
        end else if (ev == "branch") begin
            e.dp = btg; e.fl = 1; m_pc = btg; m_irv = 0;
        end else if (ev == "bkpt") begin
            m_mode = M_HALT; m_bkpt = 1; m_irv = 0;
        end else if (ev == "fetch") begin
            e.sel = 2'b00; e.en = 1; m_pc = m_pc + 1'b1; m_cnt++; m_irv = 1;
        end else if (ev == "hold") begin
            m_irv = 0;
        end
        // "stall" leaves the PC and ir_valid alone.
        q.push_back(e);
    endtask

    task automatic idle_cyc();
        cyc(0, '0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 0; branch_taken = 0; stall = 0; halt = 0; bkpt_valid = 0;
        #1;
        m_mode = M_IDLE; m_irv = 0; m_bkpt = 0; m_cnt = 0;
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_halted",   32'(halted),   32'd0);
        chk("rst_bkpt_hit", 32'(bkpt_hit), 32'd0);
        chk("rst_fetch_cnt",32'(fetch_cnt),32'd0);
        chk("rst_sel_pc",   32'(sel_pc),   32'd3);
        chk("rst_dp_pc",    32'(dp_pc),    32'(m_pc));
        chk("rst_imem_en",  32'(imem_en),  32'd0);
        chk("rst_flush",    32'(flush),    32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares whatever the stimulus side predicted for this cycle.
    exp_t me;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("sel_pc",    32'(sel_pc),    32'(me.sel));
            chk("dp_pc",     32'(dp_pc),     32'(me.dp));
            chk("imem_en",   32'(imem_en),   32'(me.en));
            chk("flush",     32'(flush),     32'(me.fl));
            chk("ir_valid",  32'(ir_valid),  32'(me.irv));
            chk("halted",    32'(halted),    32'(me.hlt));
            chk("bkpt_hit",  32'(bkpt_hit),  32'(me.bk));
            chk("fetch_cnt", 32'(fetch_cnt), 32'(me.cnt));
            if (me.en) chk("fetch_addr", 32'(pc_out), 32'(me.faddr));
        end
    end

    initial begin
        do_reset();
        idle_cyc();
        // Start at 0x010 and fetch four words.
        cyc(1, 11'h010, 0, '0, 0, 0, 0, '0);
        repeat (4) idle_cyc();
        // Reach 0x020 then branch to 0x100.
        cyc(1, 11'h01F, 0, '0, 0, 0, 0, '0);
        idle_cyc();
        cyc(0, '0, 1, 11'h100, 1, 0, 0, '0);
        repeat (2) idle_cyc();
        // Land on 0x030 with a valid fetch, stall three cycles, resume.
        cyc(0, '0, 1, 11'h02F, 0, 0, 0, '0);
        idle_cyc();
        repeat (3) cyc(0, '0, 0, '0, 1, 0, 0, '0);
        repeat (2) idle_cyc();
        // halt and start together: halt wins, start ignored.
        cyc(1, 11'h040, 0, '0, 0, 1, 0, '0);
        cyc(0, '0, 1, 11'h200, 1, 0, 0, '0);
        repeat (2) idle_cyc();
        cyc(1, 11'h000, 0, '0, 0, 0, 0, '0);
        repeat (3) idle_cyc();
        // Breakpoint at 0x005 from 0x000.
        cyc(1, 11'h000, 0, '0, 0, 0, 1, 11'h005);
        repeat (8) cyc(0, '0, 0, '0, 0, 0, 1, 11'h005);
        cyc(1, 11'h008, 0, '0, 0, 0, 0, '0);
        repeat (2) idle_cyc();
        // Reset mid-run with seven fetches counted.
        do_reset();
        cyc(1, 11'h050, 0, '0, 0, 0, 0, '0);
        repeat (7) idle_cyc();
        do_reset();
        repeat (2) idle_cyc();
        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 19) == 0,
                    PC_W'($urandom_range(0, 31)),
                    $urandom_range(0, 9) == 0,
                    PC_W'($urandom_range(0, 2047)),
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 24) == 0,
                    $urandom_range(0, 1) == 1,
                    m_pc + PC_W'($urandom_range(0, 3)));
            end
        end
        idle_cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the ARM32 core's program counter. Each cycle it computes the PC register's `sel_pc`/`dp_pc` controls. It drives the synchronous instruction-memory read enable and tags fetched instructions valid or squashed. It handles start/restart, taken branches, front-end stalls and halt, and sits between the datapath's branch/hazard logic and the PC register.

## Interface
Parameters:
- `PC_W`, 11, PC / instruction address width.
- `CNT_W`, 16, width of the fetch performance counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; (re)start execution at `start_pc`.
- `start_pc`  in  PC_W  entry address.
- `pc_out`  in  PC_W  current PC register value (feedback).
- `branch_taken`  in  1  datapath resolved a taken branch this cycle.
- `branch_target`  in  PC_W  branch destination.
- `stall`  in  1  front end must hold (downstream not accepting).
- `halt`  in  1  stop fetching.
- `bkpt_valid`  in  1  breakpoint armed (used only with `FETCH_CTRL_BKPT_EN`).
- `bkpt_addr`  in  PC_W  breakpoint address (used only with `FETCH_CTRL_BKPT_EN`).
- `sel_pc`  out  2  PC control: 01 = load `start_pc`, 11 = load `dp_pc`, 00 = increment.
- `dp_pc`  out  PC_W  load value for `sel_pc`=11.
- `imem_en`  out  1  instruction-memory read enable at address `pc_out`.
- `ir_valid`  out  1  registered; instruction word on the imem output is valid.
- `flush`  out  1  combinational; one-cycle squash of younger in-flight instructions.
- `halted`  out  1  registered; state is HALT.
- `bkpt_hit`  out  1  registered, sticky breakpoint indicator.
- `fetch_cnt`  out  CNT_W  registered count of non-squashed fetches.

## Operation
- The PC register has no hold encoding, so "hold" is expressed as `sel_pc`=11 with `dp_pc`=`pc_out`.
- FSM states: IDLE, RUN, HALT. Reset state is IDLE.
- `sel_pc`, `dp_pc`, `imem_en` and `flush` are combinational from the state and the current inputs.
- In IDLE:
  - Outputs hold the PC, with `imem_en`=0.
  - `start`=1 drives `sel_pc`=01; next state is RUN.
- In RUN, one action per cycle, in priority order `halt` > `start` > `branch_taken` > breakpoint > `stall` > normal:
  - `halt`: hold the PC, `imem_en`=0; next state is HALT.
  - `start`: `sel_pc`=01, `imem_en`=0, `flush`=1; stay in RUN.
  - `branch_taken`: `sel_pc`=11, `dp_pc`=`branch_target`, `imem_en`=0, `flush`=1.
  - Breakpoint: hold the PC, `imem_en`=0; next state is HALT; set `bkpt_hit`.
  - `stall`: hold the PC, `imem_en`=0.
  - Normal: `sel_pc`=00, `imem_en`=1.
- In HALT:
  - Outputs hold the PC, with `imem_en`=0.
  - `start` drives `sel_pc`=01, clears `bkpt_hit`, and moves to RUN.
  - `branch_taken` and `stall` are ignored.
- `ir_valid` next value:
  - 1 if `imem_en`=1 this cycle.
  - Holds its value if `stall`=1 and no higher-priority event occurs.
  - 0 otherwise, including on flush, halt and entry to IDLE.
- `fetch_cnt` increments by 1 on every cycle with `imem_en`=1. It wraps modulo 2^CNT_W and is never cleared except by reset.
- PC arithmetic belongs to the PC register. This block performs only PC_W-bit compares and muxing; no wrap handling is needed here.

## Timing
- Reset (asynchronous, on `rst_n`=0), effective immediately:
  - state=IDLE; `ir_valid`=0, `halted`=0, `bkpt_hit`=0, `fetch_cnt`=0.
  - With inputs low: `sel_pc`=11, `dp_pc`=`pc_out`, `imem_en`=0, `flush`=0.
- Reset mid-RUN aborts immediately. The PC is not reloaded until the next `start`.
- Start latency:
  - Cycle 0: `start` is high; the PC loads `start_pc` at the edge.
  - Cycle 1: `imem_en`=1 at `start_pc`.
  - Cycle 2: `ir_valid`=1.
- Branch latency: the branch cycle issues no fetch; `ir_valid`=0 in the next cycle; the target fetch occurs in the next cycle.
- `halt` takes effect in the same cycle: no fetch is issued, and `halted`=1 from the next cycle.
- `start` and `halt` in the same cycle: `halt` wins.
- `branch_taken` and `stall` together: the branch wins.

## Configuration
- `FETCH_CTRL_BKPT_EN` defined:
  - In RUN, `bkpt_valid` && `pc_out`==`bkpt_addr` with no higher-priority event blocks the fetch at that address.
  - The FSM enters HALT and `bkpt_hit` is set (sticky until `start` or reset).
- Not defined: `bkpt_valid`/`bkpt_addr` are ignored and `bkpt_hit` is constant 0. Ports remain present.

## Test plan
- Reset then `start` with `start_pc`=0x010:
  - Cycle 0: `sel_pc`=01.
  - Cycles 1-4: `sel_pc`=00, `imem_en`=1 at pc 0x010..0x013.
  - `ir_valid` high from cycle 2; `fetch_cnt`=4.
- Running at pc 0x020, `branch_taken` with target 0x100:
  - `sel_pc`=11, `dp_pc`=0x100, `flush`=1.
  - `ir_valid`=0 in the next cycle; the next fetch is at 0x100.
- `stall` held 3 cycles at pc 0x030:
  - `sel_pc`=11, `dp_pc`=0x030, `imem_en`=0, `ir_valid` held at 1, `fetch_cnt` unchanged.
  - After release, the fetch resumes at 0x030.
- `halt` and `start` in the same cycle during RUN:
  - HALT entered, `halted`=1, no fetch issued.
  - A later `start` (`start_pc`=0x000) returns to RUN, fetching 0x000.
- With `FETCH_CTRL_BKPT_EN` defined, `bkpt_addr`=0x005, start at 0x000:
  - Fetches 0x000..0x004, then HALT with `bkpt_hit`=1.
  - Without the macro, 0x005 is fetched and `bkpt_hit` stays 0.
- `rst_n` asserted mid-RUN with `fetch_cnt`=7:
  - Outputs immediately return to reset values; `fetch_cnt`=0, state IDLE.
